// File: rtl/fp_int_cvt_unit.sv
// int32 <-> IEEE-754 single converter (cvt.s.w / cvt.w.s) built around an
// iterative one-bit-per-cycle shifter, with {invalid, inexact} status flags.
module fp_int_cvt_unit (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        op_i,
  input  logic [31:0] in_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic [1:0]  out_flags_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_e;

  state_e      state_q, state_d;
  logic        op_q, op_d;
  logic        sign_q, sign_d;
  logic        sticky_q, sticky_d;
  logic [31:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;
  logic [1:0]  flg_q, flg_d;

  logic [7:0]  in_e;
  logic [22:0] in_f;
  logic [31:0] in_abs;
  logic [7:0]  cnt_full;
  logic        rnd_up;
  logic [23:0] frac_inc;

  assign in_e     = in_data_i[30:23];
  assign in_f     = in_data_i[22:0];
  assign in_abs   = in_data_i[31] ? (~in_data_i + 32'd1) : in_data_i;
  assign cnt_full = 8'd158 - in_e;

  // Round-to-nearest-even on the normalized int->float mantissa; bit 23 is the carry out.
  assign rnd_up   = mag_q[7] & ((|mag_q[6:0]) | mag_q[8]);
  assign frac_inc = {1'b0, mag_q[30:8]} + {23'd0, rnd_up};

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign out_data_o  = res_q;
  assign out_flags_o = flg_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_d   = sign_q;
    sticky_d = sticky_q;
    mag_d    = mag_q;
    exp_d    = exp_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    flg_d    = flg_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          op_d     = op_i;
          sign_d   = in_data_i[31];
          sticky_d = 1'b0;
          if (!op_i) begin
            mag_d = in_abs;
            exp_d = 8'd158;
            if (in_abs == 32'd0) begin
              res_d   = 32'd0;
              flg_d   = 2'b00;
              state_d = DONE;
            end else begin
              state_d = SHIFT;
            end
          end else if (in_e == 8'hFF) begin
            res_d   = (in_data_i[31] && in_f == 23'd0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            flg_d   = 2'b10;
            state_d = DONE;
          end else if (in_e < 8'd127) begin
            res_d   = 32'd0;
            flg_d   = {1'b0, |in_data_i[30:0]};
            state_d = DONE;
          end else if (in_e >= 8'd158) begin
            // -2^31 is the only representable value at or beyond this exponent.
            if (in_data_i == 32'hCF00_0000) begin
              res_d = 32'h8000_0000;
              flg_d = 2'b00;
            end else begin
              res_d = in_data_i[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
              flg_d = 2'b10;
            end
            state_d = DONE;
          end else begin
            mag_d   = {1'b1, in_f, 8'd0};
            cnt_d   = cnt_full[4:0];
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (!op_q) begin
          if (mag_q[31]) begin
            state_d = ROUND;
          end else begin
            mag_d = mag_q << 1;
            exp_d = exp_q - 8'd1;
          end
        end else begin
          if (cnt_q == 5'd0) begin
            state_d = ROUND;
          end else begin
            sticky_d = sticky_q | mag_q[0];
            mag_d    = mag_q >> 1;
            cnt_d    = cnt_q - 5'd1;
          end
        end
      end
      ROUND: begin
        state_d = DONE;
        if (!op_q) begin
          res_d = {sign_q, exp_q + {7'd0, frac_inc[23]}, frac_inc[22:0]};
          flg_d = {1'b0, mag_q[7] | (|mag_q[6:0])};
        end else begin
          res_d = sign_q ? (~mag_q + 32'd1) : mag_q;
          flg_d = {1'b0, sticky_q};
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      op_q     <= 1'b0;
      sign_q   <= 1'b0;
      sticky_q <= 1'b0;
      mag_q    <= 32'd0;
      exp_q    <= 8'd0;
      cnt_q    <= 5'd0;
      res_q    <= 32'd0;
      flg_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      sticky_q <= sticky_d;
      mag_q    <= mag_d;
      exp_q    <= exp_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      flg_q    <= flg_d;
    end
  end

endmodule

// File: tb/tb_fp_int_cvt_unit.sv
// Randomized + directed bench for fp_int_cvt_unit against an arithmetic reference model.
module tb_fp_int_cvt_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        op = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_flags;

  fp_int_cvt_unit dut (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .in_data_i(in_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_flags_o(out_flags)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  bit          pending = 1'b0;
  bit          lat_seen = 1'b0;
  logic [31:0] e_data;
  logic [1:0]  e_flags;
  int          e_lat;
  int          acc_edge;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: value-level conversion with explicit rounding arithmetic.
  function automatic void model(input bit o, input logic [31:0] d,
                                output logic [31:0] r, output logic [1:0] fl, output int lat);
    longint mag, q, rem, half, v, m;
    int p, e, sh;
    logic [31:0] vv;
    r = 32'd0; fl = 2'b00; lat = 1;
    if (!o) begin
      mag = d[31] ? (64'sh1_0000_0000 - longint'(d)) : longint'(d);
      if (mag == 0) return;
      p = 0;
      for (int i = 0; i < 32; i++) if (mag[i]) p = i;
      e = 127 + p;
      rem = 0;
      if (p <= 23) q = mag << (23 - p);
      else begin
        sh   = p - 23;
        q    = mag >> sh;
        rem  = mag - (q << sh);
        half = 64'sd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (64'sd1 << 24)) begin q = q >> 1; e++; end
      end
      r   = {d[31], e[7:0], q[22:0]};
      fl  = {1'b0, rem != 0};
      lat = (31 - p) + 3;
    end else begin
      e = int'(d[30:23]);
      if (e == 255) begin
        r  = (d[31] && d[22:0] == 23'd0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        fl = 2'b10;
      end else if (e < 127) begin
        fl = {1'b0, d[30:0] != 31'd0};
      end else if (e >= 158) begin
        if (d == 32'hCF00_0000) r = 32'h8000_0000;
        else begin
          r  = d[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
          fl = 2'b10;
        end
      end else begin
        m = longint'({1'b1, d[22:0]});
        rem = 0;
        if (e >= 150) v = m << (e - 150);
        else begin
          v   = m >> (150 - e);
          rem = m - (v << (150 - e));
        end
        vv  = v[31:0];
        r   = d[31] ? (32'd0 - vv) : vv;
        fl  = {1'b0, rem != 0};
        lat = 158 - e + 3;
      end
    end
  endfunction

  // Compare process: every cycle while a result is presented.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pending && out_valid) begin
        if (!lat_seen) begin
          chk("latency", edge_cnt - acc_edge + 1, e_lat);
          lat_seen = 1'b1;
        end
        chk("out_data", out_data, e_data);
        chk("out_flags", {30'd0, out_flags}, {30'd0, e_flags});
        chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
      end else if (!pending) begin
        chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
      end
    end
  end

  task automatic run(input bit o, input logic [31:0] d, input int hold);
    int guard;
    model(o, d, e_data, e_flags, e_lat);
    @(negedge clk);
    in_valid = 1'b1; op = o; in_data = d;
    guard = 0;
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    acc_edge = edge_cnt + 1;
    lat_seen = 1'b0;
    pending  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; op = ~o; in_data = $urandom;
    guard = 0;
    while (!out_valid && guard < 100) begin @(negedge clk); guard++; end
    if (!out_valid) begin
      chk("out_valid_timeout", 32'd0, 32'd1);
      pending = 1'b0;
      return;
    end
    // Stalled result with a competing request that must not be taken.
    repeat (hold) begin
      in_valid = 1'b1; op = 1'($urandom); in_data = $urandom;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    pending = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_xfer", {31'd0, in_ready}, 32'd1);
    chk("out_valid_after_xfer", {31'd0, out_valid}, 32'd0);
  endtask

  localparam int NV = 14;
  bit          v_op  [NV] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
  logic [31:0] v_in  [NV] = '{32'h00000001, 32'hFFFFFFFF, 32'h80000000, 32'h00000000,
                              32'h01000001, 32'h01000003, 32'h7FFFFFFF, 32'h40490FDB,
                              32'hC0200000, 32'h3F000000, 32'h4F000000, 32'hCF000000,
                              32'h7FC00000, 32'hFF800000};
  logic [31:0] v_out [NV] = '{32'h3F800000, 32'hBF800000, 32'hCF000000, 32'h00000000,
                              32'h4B800000, 32'h4B800002, 32'h4F000000, 32'h00000003,
                              32'hFFFFFFFE, 32'h00000000, 32'h7FFFFFFF, 32'h80000000,
                              32'h7FFFFFFF, 32'h80000000};
  logic [1:0]  v_fl  [NV] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01,
                              2'b01, 2'b01, 2'b10, 2'b00, 2'b10, 2'b10};
  int          v_lat [NV] = '{34, 0, 0, 1, 0, 0, 0, 33, 0, 1, 0, 0, 0, 0};

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete (checks=%0d)", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mr;
    logic [1:0]  mf;
    int          ml;
    logic [31:0] d;
    bit          o;
    int          ee;

    #3;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_out_flags", {30'd0, out_flags}, 32'd0);
    #10 rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      model(v_op[i], v_in[i], mr, mf, ml);
      chk("model_pin_data", mr, v_out[i]);
      chk("model_pin_flags", {30'd0, mf}, {30'd0, v_fl[i]});
      if (v_lat[i] != 0) chk("model_pin_lat", ml, v_lat[i]);
      run(v_op[i], v_in[i], (i == 7) ? 5 : 0);
    end

    // Abort mid-shift: previous result is nonzero, so the clear is observable.
    run(0, 32'h7FFFFFFF, 0);
    @(negedge clk);
    in_valid = 1'b1; op = 1'b0; in_data = 32'h00000001;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_data", out_data, 32'd0);
    chk("abort_out_flags", {30'd0, out_flags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 32'h00000001, 0);

    for (int n = 0; n < 300; n++) begin
      o = 1'($urandom);
      if (!o) begin
        d = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) d = 32'd0 - d;
      end else begin
        ee = ($urandom_range(0, 1) == 1) ? $urandom_range(120, 160) : $urandom_range(0, 255);
        d  = {1'($urandom), 8'(ee), 23'($urandom)};
      end
      run(o, d, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
